// File: rtl/digit_pair_sequencer_pkg.sv
// ============================================================================
// digit_pair_sequencer_pkg : shared online-arithmetic types and digit helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package digit_pair_sequencer_pkg;

   localparam int DIGITS_PER_WORD = 4;

   // Signed-digit encoding {plus,minus}; 2'b11 is not a legal digit
   localparam logic [1:0] POS  = 2'b10;
   localparam logic [1:0] NEG  = 2'b01;
   localparam logic [1:0] ZERO = 2'b00;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCEPT = 2'd1,
      WRITE  = 2'd2,
      DONE   = 2'd3
   } state_e;

   function automatic logic digit_legal(input logic [1:0] d);
      return (d != 2'b11);
   endfunction

endpackage

`default_nettype wire

// File: rtl/digit_pair_sequencer.sv
// ============================================================================
// digit_pair_sequencer : accepts signed-digit pairs and sequences RAM word writes
// Rev 1.0
// ============================================================================
`default_nettype none

module digit_pair_sequencer
   import digit_pair_sequencer_pkg::*;
#(
   parameter int NUM_WORDS_MAX = 128
) (
   input  logic                                                clk,
   input  logic                                                rst_n,
   input  logic                                                start,
   input  logic [$clog2(NUM_WORDS_MAX)-1:0]                    num_words,
   input  logic                                                in_valid,
   input  logic [1:0]                                          x_digit,
   input  logic [1:0]                                          y_digit,
   output logic                                                in_ready,
   output logic [1:0]                                          x_input,
   output logic [1:0]                                          y_input,
   output logic [$clog2(NUM_WORDS_MAX*DIGITS_PER_WORD)-1:0]    cnt,
   output logic [$clog2(NUM_WORDS_MAX)-1:0]                    computation_cycles,
   output logic                                                we,
   output logic                                                write_enable,
   output logic                                                busy,
   output logic                                                done,
   output logic                                                digit_err
);

   localparam int AW = $clog2(NUM_WORDS_MAX);
   localparam int CW = $clog2(NUM_WORDS_MAX*DIGITS_PER_WORD);
   localparam logic [1:0] LAST_NIB = 2'(DIGITS_PER_WORD-1);

   typedef logic [AW-1:0] addr_t;
   typedef logic [CW:0]   cnt_ext_t;

   state_e        state_q, state_d;
   addr_t         num_words_q, num_words_d;
   addr_t         cc_q, cc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    x_q, x_d, y_q, y_d;
   logic          err_q, err_d;
   logic          in_ready_q, in_ready_d;
   logic          we_q, we_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   cnt_ext_t      next_cnt_w;
   cnt_ext_t      target_w;

   // One extra bit so a full 0-means-max load (512 digits) is comparable
   assign next_cnt_w = cnt_ext_t'(cnt_q) + cnt_ext_t'(1);
   assign target_w   = (num_words_q == '0) ? cnt_ext_t'(NUM_WORDS_MAX*DIGITS_PER_WORD)
                                           : cnt_ext_t'(num_words_q) * cnt_ext_t'(DIGITS_PER_WORD);

   always_comb begin
      state_d     = state_q;
      num_words_d = num_words_q;
      cc_d        = cc_q;
      cnt_d       = cnt_q;
      x_d         = x_q;
      y_d         = y_q;
      err_d       = err_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d     = ACCEPT;
               num_words_d = num_words;
               cc_d        = '0;
               cnt_d       = '0;
               err_d       = 1'b0;
            end
         end
         ACCEPT: begin
            if (in_valid) begin
               x_d     = digit_legal(x_digit) ? x_digit : ZERO;
               y_d     = digit_legal(y_digit) ? y_digit : ZERO;
               err_d   = err_q | ~digit_legal(x_digit) | ~digit_legal(y_digit);
               state_d = WRITE;
            end
         end
         WRITE: begin
            cnt_d = next_cnt_w[CW-1:0];
            if (cnt_q[1:0] == LAST_NIB) begin
               cc_d = cc_q + addr_t'(1);
            end
            state_d = (next_cnt_w == target_w) ? DONE : ACCEPT;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Status strobes are decoded from the next state so they register alongside it
   always_comb begin
      in_ready_d = (state_d == ACCEPT);
      we_d       = (state_d == WRITE);
      done_d     = (state_d == DONE);
      busy_d     = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         num_words_q <= '0;
         cc_q        <= '0;
         cnt_q       <= '0;
         x_q         <= '0;
         y_q         <= '0;
         err_q       <= 1'b0;
         in_ready_q  <= 1'b0;
         we_q        <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         num_words_q <= num_words_d;
         cc_q        <= cc_d;
         cnt_q       <= cnt_d;
         x_q         <= x_d;
         y_q         <= y_d;
         err_q       <= err_d;
         in_ready_q  <= in_ready_d;
         we_q        <= we_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign in_ready           = in_ready_q;
   assign x_input            = x_q;
   assign y_input            = y_q;
   assign cnt                = cnt_q;
   assign computation_cycles = cc_q;
   assign we                 = we_q;
   assign write_enable       = we_q;
   assign busy               = busy_q;
   assign done               = done_q;
   assign digit_err          = err_q;

endmodule

`default_nettype wire

// File: tb/tb_digit_pair_sequencer.sv
// ============================================================================
// tb_digit_pair_sequencer : scoreboard bench for digit_pair_sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_digit_pair_sequencer;
   import digit_pair_sequencer_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [6:0] num_words = '0;
   logic       in_valid = 1'b0;
   logic [1:0] x_digit = '0;
   logic [1:0] y_digit = '0;
   logic       in_ready;
   logic [1:0] x_input, y_input;
   logic [8:0] cnt;
   logic [6:0] computation_cycles;
   logic       we, write_enable, busy, done, digit_err;

   digit_pair_sequencer #(.NUM_WORDS_MAX(128)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .num_words(num_words),
      .in_valid(in_valid), .x_digit(x_digit), .y_digit(y_digit),
      .in_ready(in_ready), .x_input(x_input), .y_input(y_input),
      .cnt(cnt), .computation_cycles(computation_cycles),
      .we(we), .write_enable(write_enable),
      .busy(busy), .done(done), .digit_err(digit_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int first_acc = 0;
   int last_acc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [1:0] x;
      logic [1:0] y;
      logic [8:0] cnt;
      logic [6:0] cc;
   } exp_t;

   exp_t sb[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every write strobe consumes one expected entry
   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n && (we || write_enable)) begin
         check("we_we_pair", {30'd0, we, write_enable}, 32'd3);
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write: got cnt %0d expected no write", cnt);
         end else begin
            e = sb.pop_front();
            check("wr_x_input", x_input, e.x);
            check("wr_y_input", y_input, e.y);
            check("wr_cnt", cnt, e.cnt);
            check("wr_cc", computation_cycles, e.cc);
         end
      end
   end

   task automatic do_start(input logic [6:0] nw);
      @(posedge clk);
      #1 start = 1'b1;
      num_words = nw;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic send(input logic [1:0] x, input logic [1:0] y,
                       input logic [1:0] ex, input logic [1:0] ey,
                       input int ecnt, input int ecc);
      exp_t e;
      bit got;
      got = 1'b0;
      e.x = ex;
      e.y = ey;
      e.cnt = 9'(ecnt);
      e.cc = 7'(ecc);
      sb.push_back(e);
      in_valid = 1'b1;
      x_digit = x;
      y_digit = y;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         checks++;
         failures++;
         $display("FAIL handshake_timeout: got in_ready 0 expected 1 (cnt %0d)", ecnt);
      end
      last_acc = cyc;
      @(posedge clk);
      #1 in_valid = 1'b0;
      x_digit = '0;
      y_digit = '0;
   endtask

   // Latency is counted from the cycle in which the handshake was presented
   task automatic wait_done(input int ref_cyc, input int exp_lat, input string name);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         checks++;
         failures++;
         $display("FAIL %s: got no done expected done within 20 cycles", name);
      end else begin
         check(name, cyc - ref_cyc, exp_lat);
         @(negedge clk);
         check("done_one_cycle", {30'd0, done, busy}, 32'd0);
      end
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1);
   end

   initial begin : stim
      repeat (3) @(posedge clk);
      #1;
      check("rst_ctl", {26'd0, in_ready, busy, done, we, write_enable, digit_err}, 32'd0);
      check("rst_cnt", cnt, 32'd0);
      check("rst_cc", computation_cycles, 32'd0);
      check("rst_xy", {x_input, y_input}, 32'd0);
      rst_n = 1'b1;

      // Single word, back-to-back pairs
      do_start(7'd1);
      send(POS, NEG, POS, NEG, 0, 0);
      first_acc = last_acc;
      send(NEG, POS, NEG, POS, 1, 0);
      send(ZERO, POS, ZERO, POS, 2, 0);
      send(POS, POS, POS, POS, 3, 0);
      wait_done(first_acc, 8, "done_lat_nw1");
      check("nw1_end_cnt", cnt, 32'd4);
      check("nw1_end_cc", computation_cycles, 32'd1);
      check("nw1_no_err", digit_err, 32'd0);

      // Two words: address steps after the fourth write
      do_start(7'd2);
      for (int i = 0; i < 8; i++) begin
         send(NEG, ZERO, NEG, ZERO, i, i / 4);
         if (i == 3) begin
            @(posedge clk);
            #1 check("nw2_cc_step", computation_cycles, 32'd1);
         end
      end
      wait_done(last_acc, 2, "done_lat_nw2");

      // Stall mid-word, plus an ignored start while busy
      do_start(7'd1);
      send(POS, ZERO, POS, ZERO, 0, 0);
      send(ZERO, NEG, ZERO, NEG, 1, 0);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_ctl", {30'd0, in_ready, we}, 32'd2);
         check("hold_cnt", cnt, 32'd2);
      end
      @(posedge clk);
      #1 start = 1'b1;
      num_words = 7'd3;
      @(posedge clk);
      #1 start = 1'b0;
      check("busy_start_cnt", cnt, 32'd2);
      check("busy_start_busy", busy, 32'd1);
      send(NEG, NEG, NEG, NEG, 2, 0);
      send(POS, ZERO, POS, ZERO, 3, 0);
      wait_done(last_acc, 2, "done_after_hold");

      // Illegal digits are zeroed and flagged
      do_start(7'd1);
      send(2'b11, POS, ZERO, POS, 0, 0);
      check("err_set", digit_err, 32'd1);
      send(NEG, 2'b11, NEG, ZERO, 1, 0);
      send(ZERO, ZERO, ZERO, ZERO, 2, 0);
      send(POS, POS, POS, POS, 3, 0);
      wait_done(last_acc, 2, "done_err_load");
      check("err_sticky", digit_err, 32'd1);
      do_start(7'd1);
      check("err_cleared", digit_err, 32'd0);

      // Asynchronous reset in the middle of a WRITE cycle
      send(POS, NEG, POS, NEG, 0, 0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_ctl", {26'd0, in_ready, busy, done, we, write_enable, digit_err}, 32'd0);
      check("arst_cnt", cnt, 32'd0);
      check("arst_cc", computation_cycles, 32'd0);
      check("arst_xy", {x_input, y_input}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      do_start(7'd1);
      send(NEG, POS, NEG, POS, 0, 0);
      send(POS, NEG, POS, NEG, 1, 0);
      send(ZERO, ZERO, ZERO, ZERO, 2, 0);
      send(NEG, NEG, NEG, NEG, 3, 0);
      wait_done(last_acc, 2, "done_after_arst");

      // num_words=0 means 128 words; 512 reads back as 0 on the 9-bit cnt
      do_start(7'd0);
      for (int i = 0; i < 512; i++) begin
         send(POS, ZERO, POS, ZERO, i, i / 4);
      end
      wait_done(last_acc, 2, "done_lat_nw0");
      check("nw0_cnt_wrap", cnt, 32'd0);
      check("nw0_cc_wrap", computation_cycles, 32'd0);

      check("sb_drained", sb.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
